io_responder: RTL and testbench

IO_RESPONDER -- requirements
Module: io_responder

---
 rtl/io_responder_pkg.sv | 17 +
 rtl/io_responder_if.sv | 28 ++
 rtl/io_debounce.sv | 32 +++
 rtl/io_responder.sv | 129 ++++++++++++
 tb/tb_io_responder.sv | 218 +++++++++++++++++++++
 5 files changed

// File: rtl/io_responder_pkg.sv
// Shared types and constants for the IO responder: input FSM state,
// output register addresses and bus widths.
package io_responder_pkg;

  localparam int DATA_W = 32;
  localparam int ADDR_W = 21;

  localparam logic [ADDR_W-1:0] ADDR_DST0 = 21'd0;
  localparam logic [ADDR_W-1:0] ADDR_DST1 = 21'd1;
  localparam logic [ADDR_W-1:0] ADDR_DST2 = 21'd2;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_HELD = 1'b1
  } state_t;

endpackage

// File: rtl/io_responder_if.sv
// Processor-side IO bus of the responder: store strobe/address/data,
// captured-word read handshake, status flags and the output registers.
interface io_responder_if;
  import io_responder_pkg::*;

  logic              wr_en;
  logic [ADDR_W-1:0] wr_addr;
  logic [DATA_W-1:0] wr_data;
  logic              rd_en;
  logic [DATA_W-1:0] rd_data;
  logic              in_ready;
  logic              overrun;
  logic              wr_err;
  logic [DATA_W-1:0] dst0;
  logic [DATA_W-1:0] dst1;
  logic [DATA_W-1:0] dst2;

  modport master (
    output wr_en, wr_addr, wr_data, rd_en,
    input  rd_data, in_ready, overrun, wr_err, dst0, dst1, dst2
  );

  modport slave (
    input  wr_en, wr_addr, wr_data, rd_en,
    output rd_data, in_ready, overrun, wr_err, dst0, dst1, dst2
  );

endinterface

// File: rtl/io_debounce.sv
// Button debouncer: the stable level follows the synchronized level only
// after it has differed for DEBOUNCE_CYCLES consecutive edges; any return
// to the stable level restarts the count. Resets to released (1).
module io_debounce #(
  parameter int DEBOUNCE_CYCLES = 4
) (
  input  logic clock,
  input  logic reset,
  input  logic sync_in,
  output logic stable
);

  localparam logic [7:0] LIMIT = 8'(DEBOUNCE_CYCLES - 1);

  logic [7:0] count;

  // Count consecutive disagreeing edges; flip the stable level on the last one
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      stable <= 1'b1;
      count  <= 8'd0;
    end else if (sync_in == stable) begin
      count  <= 8'd0;
    end else if (count == LIMIT) begin
      stable <= sync_in;
      count  <= 8'd0;
    end else begin
      count  <= count + 8'd1;
    end
  end

endmodule

// File: rtl/io_responder.sv
// IO responder: three memory-mapped output registers with an unmapped-write
// error pulse, plus a switch-word capture path triggered by a confirm button.
// Build option: define IO_RESPONDER_DEBOUNCE_EN to debounce the button;
// otherwise the synchronized button level is used directly.
module io_responder
  import io_responder_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 4,
  parameter int SW_WIDTH        = 18
) (
  input  logic                clock,
  input  logic                reset,
  input  logic [SW_WIDTH-1:0] sw_in,
  input  logic                btn_n,
  io_responder_if.slave       bus
);

  if (DEBOUNCE_CYCLES < 1 || DEBOUNCE_CYCLES > 255) begin : g_param_check
    $error("io_responder: DEBOUNCE_CYCLES must be 1..255");
  end

  logic [DATA_W-1:0]   dst0_r, dst1_r, dst2_r;
  logic                wr_err_r;
  logic [SW_WIDTH-1:0] sw_p0, sw_p1;
  logic                btn_p0, btn_p1;
  logic                btn_stable;
  logic                btn_prev;
  logic                press;
  state_t              state;
  logic [SW_WIDTH-1:0] hold;
  logic                in_ready_r;
  logic                overrun_r;

  // Output register writes; unmapped addresses raise a one-cycle error
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      dst0_r   <= '0;
      dst1_r   <= '0;
      dst2_r   <= '0;
      wr_err_r <= 1'b0;
    end else begin
      wr_err_r <= 1'b0;
      if (bus.wr_en) begin
        case (bus.wr_addr)
          ADDR_DST0: dst0_r   <= bus.wr_data;
          ADDR_DST1: dst1_r   <= bus.wr_data;
          ADDR_DST2: dst2_r   <= bus.wr_data;
          default:   wr_err_r <= 1'b1;
        endcase
      end
    end
  end

  // Two-flop synchronizers for the asynchronous switches and button
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      sw_p0  <= '0;
      sw_p1  <= '0;
      btn_p0 <= 1'b1;
      btn_p1 <= 1'b1;
    end else begin
      sw_p0  <= sw_in;
      sw_p1  <= sw_p0;
      btn_p0 <= btn_n;
      btn_p1 <= btn_p0;
    end
  end

`ifdef IO_RESPONDER_DEBOUNCE_EN
  io_debounce #(
    .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
  ) u_debounce (
    .clock   (clock),
    .reset   (reset),
    .sync_in (btn_p1),
    .stable  (btn_stable)
  );
`else
  assign btn_stable = btn_p1;
`endif

  // A press is the released-to-pressed transition of the stable level, so a
  // held button yields exactly one capture
  assign press = btn_prev & ~btn_stable;

  // Input FSM: capture on press, hand the word over on rd_en, flag overwrites
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state      <= ST_IDLE;
      hold       <= '0;
      in_ready_r <= 1'b0;
      overrun_r  <= 1'b0;
      btn_prev   <= 1'b1;
    end else begin
      btn_prev <= btn_stable;
      case (state)
        ST_IDLE: begin
          if (press) begin
            hold       <= sw_p1;
            state      <= ST_HELD;
            in_ready_r <= 1'b1;
          end
        end
        ST_HELD: begin
          if (press) begin
            hold <= sw_p1;
            if (!bus.rd_en) overrun_r <= 1'b1;
          end else if (bus.rd_en) begin
            state      <= ST_IDLE;
            in_ready_r <= 1'b0;
          end
        end
        default: begin
          state      <= ST_IDLE;
          in_ready_r <= 1'b0;
        end
      endcase
    end
  end

  assign bus.dst0     = dst0_r;
  assign bus.dst1     = dst1_r;
  assign bus.dst2     = dst2_r;
  assign bus.wr_err   = wr_err_r;
  assign bus.rd_data  = DATA_W'(hold);
  assign bus.in_ready = in_ready_r;
  assign bus.overrun  = overrun_r;

endmodule

// File: tb/tb_io_responder.sv
// Directed testbench for io_responder; expected capture latency follows
// the IO_RESPONDER_DEBOUNCE_EN build option.
module tb_io_responder;

`ifdef IO_RESPONDER_DEBOUNCE_EN
  localparam int LAT = 7;
  localparam int PRE = 4;
`else
  localparam int LAT = 3;
  localparam int PRE = 2;
`endif

  logic        clock;
  logic        reset;
  logic [17:0] sw_in;
  logic        btn_n;
  int          checks;
  int          errors;

  io_responder_if bus ();

  io_responder #(
    .DEBOUNCE_CYCLES (4),
    .SW_WIDTH        (18)
  ) dut (
    .clock (clock),
    .reset (reset),
    .sw_in (sw_in),
    .btn_n (btn_n),
    .bus   (bus)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic test_reset();
    checks++; if (bus.dst0 !== 32'h0) begin errors++; $display("FAIL reset_dst0: got %h expected %h", bus.dst0, 32'h0); end
    checks++; if (bus.dst1 !== 32'h0) begin errors++; $display("FAIL reset_dst1: got %h expected %h", bus.dst1, 32'h0); end
    checks++; if (bus.dst2 !== 32'h0) begin errors++; $display("FAIL reset_dst2: got %h expected %h", bus.dst2, 32'h0); end
    checks++; if (bus.in_ready !== 1'b0) begin errors++; $display("FAIL reset_in_ready: got %b expected 0", bus.in_ready); end
    checks++; if (bus.overrun !== 1'b0) begin errors++; $display("FAIL reset_overrun: got %b expected 0", bus.overrun); end
    checks++; if (bus.wr_err !== 1'b0) begin errors++; $display("FAIL reset_wr_err: got %b expected 0", bus.wr_err); end
    checks++; if (bus.rd_data !== 32'h0) begin errors++; $display("FAIL reset_rd_data: got %h expected %h", bus.rd_data, 32'h0); end
  endtask

  task automatic test_write();
    bus.wr_en = 1'b1; bus.wr_addr = 21'd1; bus.wr_data = 32'hDEADBEEF;
    tick();
    bus.wr_en = 1'b0;
    checks++; if (bus.dst1 !== 32'hDEADBEEF) begin errors++; $display("FAIL write_dst1: got %h expected %h", bus.dst1, 32'hDEADBEEF); end
    checks++; if (bus.dst0 !== 32'h0) begin errors++; $display("FAIL write_dst0_untouched: got %h expected %h", bus.dst0, 32'h0); end
    checks++; if (bus.dst2 !== 32'h0) begin errors++; $display("FAIL write_dst2_untouched: got %h expected %h", bus.dst2, 32'h0); end
    checks++; if (bus.wr_err !== 1'b0) begin errors++; $display("FAIL write_wr_err: got %b expected 0", bus.wr_err); end
    bus.wr_en = 1'b1; bus.wr_addr = 21'd0; bus.wr_data = 32'h11111111;
    tick();
    bus.wr_addr = 21'd2; bus.wr_data = 32'h22222222;
    tick();
    bus.wr_en = 1'b0; bus.wr_addr = 21'd0; bus.wr_data = 32'hFFFFFFFF;
    tick();
    checks++; if (bus.dst0 !== 32'h11111111) begin errors++; $display("FAIL write_dst0: got %h expected %h", bus.dst0, 32'h11111111); end
    checks++; if (bus.dst2 !== 32'h22222222) begin errors++; $display("FAIL write_dst2: got %h expected %h", bus.dst2, 32'h22222222); end
    checks++; if (bus.dst1 !== 32'hDEADBEEF) begin errors++; $display("FAIL write_dst1_kept: got %h expected %h", bus.dst1, 32'hDEADBEEF); end
  endtask

  task automatic test_unmapped();
    bus.wr_en = 1'b1; bus.wr_addr = 21'd5; bus.wr_data = 32'h00001234;
    tick();
    bus.wr_en = 1'b0;
    checks++; if (bus.wr_err !== 1'b1) begin errors++; $display("FAIL unmapped_wr_err_pulse: got %b expected 1", bus.wr_err); end
    checks++; if (bus.dst0 !== 32'h11111111) begin errors++; $display("FAIL unmapped_dst0: got %h expected %h", bus.dst0, 32'h11111111); end
    checks++; if (bus.dst1 !== 32'hDEADBEEF) begin errors++; $display("FAIL unmapped_dst1: got %h expected %h", bus.dst1, 32'hDEADBEEF); end
    checks++; if (bus.dst2 !== 32'h22222222) begin errors++; $display("FAIL unmapped_dst2: got %h expected %h", bus.dst2, 32'h22222222); end
    tick();
    checks++; if (bus.wr_err !== 1'b0) begin errors++; $display("FAIL unmapped_wr_err_drop: got %b expected 0", bus.wr_err); end
    bus.wr_en = 1'b1; bus.wr_addr = 21'd3; bus.wr_data = 32'hAAAA5555;
    tick();
    bus.wr_addr = 21'd2; bus.wr_data = 32'h0000BEEF;
    tick();
    bus.wr_en = 1'b0;
    checks++; if (bus.wr_err !== 1'b0) begin errors++; $display("FAIL b2b_wr_err_after_mapped: got %b expected 0", bus.wr_err); end
    checks++; if (bus.dst2 !== 32'h0000BEEF) begin errors++; $display("FAIL b2b_dst2: got %h expected %h", bus.dst2, 32'h0000BEEF); end
    bus.wr_en = 1'b1; bus.wr_addr = 21'h1FFFFF; bus.wr_data = 32'h0;
    tick();
    bus.wr_en = 1'b0;
    checks++; if (bus.wr_err !== 1'b1) begin errors++; $display("FAIL unmapped_top_addr: got %b expected 1", bus.wr_err); end
    tick();
  endtask

  task automatic test_capture();
    sw_in = 18'h2A5A5; btn_n = 1'b0;
    repeat (LAT - 1) tick();
    checks++; if (bus.in_ready !== 1'b0) begin errors++; $display("FAIL capture_early: got %b expected 0", bus.in_ready); end
    tick();
    checks++; if (bus.in_ready !== 1'b1) begin errors++; $display("FAIL capture_in_ready: got %b expected 1", bus.in_ready); end
    checks++; if (bus.rd_data !== 32'h0002A5A5) begin errors++; $display("FAIL capture_rd_data: got %h expected %h", bus.rd_data, 32'h0002A5A5); end
    checks++; if (bus.overrun !== 1'b0) begin errors++; $display("FAIL capture_overrun: got %b expected 0", bus.overrun); end
    bus.rd_en = 1'b1;
    tick();
    bus.rd_en = 1'b0;
    checks++; if (bus.in_ready !== 1'b0) begin errors++; $display("FAIL consume_in_ready: got %b expected 0", bus.in_ready); end
    checks++; if (bus.rd_data !== 32'h0002A5A5) begin errors++; $display("FAIL consume_hold_kept: got %h expected %h", bus.rd_data, 32'h0002A5A5); end
    sw_in = 18'h00001;
    repeat (12) tick();
    checks++; if (bus.in_ready !== 1'b0) begin errors++; $display("FAIL held_button_single_capture: got %b expected 0", bus.in_ready); end
    btn_n = 1'b1;
    repeat (LAT + 3) tick();
  endtask

  task automatic test_rd_idle();
    bus.rd_en = 1'b1;
    tick();
    tick();
    bus.rd_en = 1'b0;
    checks++; if (bus.in_ready !== 1'b0) begin errors++; $display("FAIL rd_idle_in_ready: got %b expected 0", bus.in_ready); end
    checks++; if (bus.overrun !== 1'b0) begin errors++; $display("FAIL rd_idle_overrun: got %b expected 0", bus.overrun); end
    checks++; if (bus.rd_data !== 32'h0002A5A5) begin errors++; $display("FAIL rd_idle_rd_data: got %h expected %h", bus.rd_data, 32'h0002A5A5); end
  endtask

  task automatic test_glitch();
    sw_in = 18'h3FFFF; btn_n = 1'b0;
    repeat (3) tick();
    btn_n = 1'b1;
    repeat (12) tick();
    checks++; if (bus.in_ready !== 1'b0) begin errors++; $display("FAIL glitch_in_ready: got %b expected 0", bus.in_ready); end
    checks++; if (bus.rd_data !== 32'h0002A5A5) begin errors++; $display("FAIL glitch_rd_data: got %h expected %h", bus.rd_data, 32'h0002A5A5); end
  endtask

  task automatic test_overrun();
    sw_in = 18'h12345; btn_n = 1'b0;
    repeat (LAT) tick();
    checks++; if (bus.rd_data !== 32'h00012345) begin errors++; $display("FAIL overrun_first_capture: got %h expected %h", bus.rd_data, 32'h00012345); end
    btn_n = 1'b1;
    repeat (LAT + 2) tick();
    sw_in = 18'h00011; btn_n = 1'b0;
    repeat (LAT - 1) tick();
    checks++; if (bus.overrun !== 1'b0) begin errors++; $display("FAIL overrun_early: got %b expected 0", bus.overrun); end
    tick();
    checks++; if (bus.in_ready !== 1'b1) begin errors++; $display("FAIL overrun_in_ready: got %b expected 1", bus.in_ready); end
    checks++; if (bus.rd_data !== 32'h00000011) begin errors++; $display("FAIL overrun_rd_data: got %h expected %h", bus.rd_data, 32'h00000011); end
    checks++; if (bus.overrun !== 1'b1) begin errors++; $display("FAIL overrun_set: got %b expected 1", bus.overrun); end
    bus.rd_en = 1'b1;
    tick();
    bus.rd_en = 1'b0;
    checks++; if (bus.in_ready !== 1'b0) begin errors++; $display("FAIL overrun_consume: got %b expected 0", bus.in_ready); end
    checks++; if (bus.overrun !== 1'b1) begin errors++; $display("FAIL overrun_sticky: got %b expected 1", bus.overrun); end
    btn_n = 1'b1;
    repeat (LAT + 3) tick();
  endtask

  task automatic test_reset_mid_debounce();
    sw_in = 18'h2A5A5; btn_n = 1'b0;
    repeat (PRE) tick();
    reset = 1'b0;
    #1;
    checks++; if (bus.dst0 !== 32'h0) begin errors++; $display("FAIL midrst_dst0: got %h expected %h", bus.dst0, 32'h0); end
    checks++; if (bus.dst1 !== 32'h0) begin errors++; $display("FAIL midrst_dst1: got %h expected %h", bus.dst1, 32'h0); end
    checks++; if (bus.dst2 !== 32'h0) begin errors++; $display("FAIL midrst_dst2: got %h expected %h", bus.dst2, 32'h0); end
    checks++; if (bus.rd_data !== 32'h0) begin errors++; $display("FAIL midrst_rd_data: got %h expected %h", bus.rd_data, 32'h0); end
    checks++; if (bus.overrun !== 1'b0) begin errors++; $display("FAIL midrst_overrun: got %b expected 0", bus.overrun); end
    tick();
    checks++; if (bus.in_ready !== 1'b0) begin errors++; $display("FAIL midrst_in_ready: got %b expected 0", bus.in_ready); end
    reset = 1'b1;
    repeat (LAT - 1) tick();
    checks++; if (bus.in_ready !== 1'b0) begin errors++; $display("FAIL midrst_no_early_capture: got %b expected 0", bus.in_ready); end
    tick();
    checks++; if (bus.in_ready !== 1'b1) begin errors++; $display("FAIL midrst_capture: got %b expected 1", bus.in_ready); end
    checks++; if (bus.rd_data !== 32'h0002A5A5) begin errors++; $display("FAIL midrst_capture_data: got %h expected %h", bus.rd_data, 32'h0002A5A5); end
  endtask

  task automatic test_same_edge();
    btn_n = 1'b1;
    repeat (LAT + 2) tick();
    sw_in = 18'h3C3C3; btn_n = 1'b0;
    repeat (LAT - 1) tick();
    bus.rd_en = 1'b1;
    tick();
    bus.rd_en = 1'b0;
    checks++; if (bus.in_ready !== 1'b1) begin errors++; $display("FAIL same_edge_in_ready: got %b expected 1", bus.in_ready); end
    checks++; if (bus.rd_data !== 32'h0003C3C3) begin errors++; $display("FAIL same_edge_rd_data: got %h expected %h", bus.rd_data, 32'h0003C3C3); end
    checks++; if (bus.overrun !== 1'b0) begin errors++; $display("FAIL same_edge_overrun: got %b expected 0", bus.overrun); end
    repeat (3) tick();
    checks++; if (bus.in_ready !== 1'b1) begin errors++; $display("FAIL same_edge_stays_held: got %b expected 1", bus.in_ready); end
  endtask

  initial begin
    checks      = 0;
    errors      = 0;
    reset       = 1'b0;
    sw_in       = '0;
    btn_n       = 1'b1;
    bus.wr_en   = 1'b0;
    bus.wr_addr = '0;
    bus.wr_data = '0;
    bus.rd_en   = 1'b0;
    repeat (2) tick();
    test_reset();
    reset = 1'b1;
    tick();
    test_write();
    test_unmapped();
    test_capture();
    test_rd_idle();
`ifdef IO_RESPONDER_DEBOUNCE_EN
    test_glitch();
`endif
    test_overrun();
    test_reset_mid_debounce();
    test_same_edge();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
